// File: rtl/option22_pkg.sv
// rtl/option22_pkg.sv - shared encodings and state type for the option22 host driver
package option22_pkg;

    localparam int DEFAULT_WORD_COUNT = 64;

    // Command opcodes carried on cmd_op_i; 2'b11 is reserved and behaves as a read.
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_INIT  = 2'b10;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_e;

endpackage

// File: rtl/option22_clkgen.sv
// rtl/option22_clkgen.sv - half-period divider for the memory shift clock
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   en_i          count while high; the counter parks at zero when low
//   phase_end_o   high in the last system cycle of each CLK_DIV-cycle phase
module option22_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic phase_end_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    assign phase_end_o = en_i && (div_q == DIV_LAST);

    // Parking at zero while disabled means every phase starts on a fresh count.
    always_comb begin
        div_d = '0;
        if (en_i && (div_q != DIV_LAST)) begin
            div_d = div_q + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/option22_host.sv
// rtl/option22_host.sv - byte command host that bit-serialises into the option22 ring memory
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o  command handshake; ready only while idle
//   cmd_op_i, cmd_data_i       opcode (write/read/re-init) and write byte
//   rsp_valid_o, rsp_data_o    one-cycle read strobe; data held until the next read
//   word_idx_o                 byte operations since last init, modulo WORD_COUNT
//   mem_clk_o .. mem_din_o     memory control: shift clock, reset, write enable, data bit
//   mem_out_i                  memory word output
module option22_host
    import option22_pkg::*;
#(
    parameter int WORD_COUNT  = DEFAULT_WORD_COUNT,
    parameter int CLK_DIV     = 2,
    parameter int INIT_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [1:0]                    cmd_op_i,
    input  logic [7:0]                    cmd_data_i,
    output logic                          rsp_valid_o,
    output logic [7:0]                    rsp_data_o,
    output logic [$clog2(WORD_COUNT)-1:0] word_idx_o,
    output logic                          mem_clk_o,
    output logic                          mem_reset_o,
    output logic                          mem_write_o,
    output logic                          mem_din_o,
    input  logic [7:0]                    mem_out_i
);

    localparam int IW = $clog2(WORD_COUNT);
    localparam int NW = $clog2(INIT_CYCLES + 1);
    localparam logic [NW-1:0] INIT_LAST = NW'(INIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(WORD_COUNT - 1);

    state_e        state_q, state_d;
    logic [NW-1:0] init_cnt_q, init_cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    bit_dec;
    logic [7:0]    data_q, data_d;
    logic          is_write_q, is_write_d;
    logic [IW-1:0] word_idx_q, word_idx_d;
    logic          mem_clk_q, mem_clk_d;
    logic          mem_reset_q, mem_reset_d;
    logic          mem_write_q, mem_write_d;
    logic          mem_din_q, mem_din_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          phase_end;
    logic          shifting;

    assign shifting = (state_q == ST_LOW) || (state_q == ST_HIGH);
    assign bit_dec  = bit_q - 3'd1;

    option22_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .clk        (clk),
        .reset      (reset),
        .en_i       (shifting),
        .phase_end_o(phase_end)
    );

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign word_idx_o  = word_idx_q;
    assign mem_clk_o   = mem_clk_q;
    assign mem_reset_o = mem_reset_q;
    assign mem_write_o = mem_write_q;
    assign mem_din_o   = mem_din_q;

    // All memory-facing outputs are registered and updated on the edge that
    // enters a state, so each one is glitch-free and aligned with its phase.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        bit_d       = bit_q;
        data_d      = data_q;
        is_write_d  = is_write_q;
        word_idx_d  = word_idx_q;
        mem_clk_d   = mem_clk_q;
        mem_reset_d = mem_reset_q;
        mem_write_d = mem_write_q;
        mem_din_d   = mem_din_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            ST_INIT: begin
                mem_clk_d  = 1'b0;
                word_idx_d = '0;
                bit_d      = '0;
                if (init_cnt_q == INIT_LAST) begin
                    init_cnt_d  = '0;
                    mem_reset_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    init_cnt_d  = init_cnt_q + NW'(1);
                    mem_reset_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    data_d = cmd_data_i;
                    if (cmd_op_i == OP_INIT) begin
                        init_cnt_d  = '0;
                        mem_reset_d = 1'b1;
                        word_idx_d  = '0;
                        state_d     = ST_INIT;
                    end else begin
                        is_write_d  = (cmd_op_i == OP_WRITE);
                        mem_write_d = (cmd_op_i == OP_WRITE);
                        mem_din_d   = (cmd_op_i == OP_WRITE) && cmd_data_i[7];
                        bit_d       = 3'd7;
                        state_d     = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                if (phase_end) begin
                    mem_clk_d = 1'b1;
                    state_d   = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    mem_clk_d = 1'b0;
                    if (bit_q == 3'd0) begin
                        // Sampled CLK_DIV cycles after the 8th rising edge.
                        mem_write_d = 1'b0;
                        rsp_valid_d = !is_write_q;
                        if (!is_write_q) begin
                            rsp_data_d = mem_out_i;
                        end
                        state_d = ST_DONE;
                    end else begin
                        bit_d     = bit_dec;
                        mem_din_d = is_write_q && data_q[bit_dec];
                        state_d   = ST_LOW;
                    end
                end
            end
            ST_DONE: begin
                word_idx_d = (word_idx_q == IDX_LAST) ? '0 : word_idx_q + IW'(1);
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            bit_q       <= '0;
            data_q      <= '0;
            is_write_q  <= 1'b0;
            word_idx_q  <= '0;
            mem_clk_q   <= 1'b0;
            mem_reset_q <= 1'b1;
            mem_write_q <= 1'b0;
            mem_din_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            bit_q       <= bit_d;
            data_q      <= data_d;
            is_write_q  <= is_write_d;
            word_idx_q  <= word_idx_d;
            mem_clk_q   <= mem_clk_d;
            mem_reset_q <= mem_reset_d;
            mem_write_q <= mem_write_d;
            mem_din_q   <= mem_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule
